// File: rtl/lm71_spi_master.sv
// lm71_spi_master: Wishbone-slave, 3-wire SPI master for the LM71 temperature sensor.
// Each transaction reads a 16-bit word from the sensor. If WR_EN is set, it then
// writes a 16-bit word back to the sensor. The pad tristate lives outside this
// block: TEMP_SIO = o_so_oe ? o_so : 1'bz.
// Ports:
//   i_clk, i_rst              system clock, asynchronous active-low reset
//   i_wb_adr/dat/we/cyc/stb   Wishbone slave request (0=CTRL/STATUS, 1=RXDATA)
//   o_wb_dat, o_wb_ack        registered read data and single-cycle acknowledge
//   o_irq                     level interrupt, DONE & IE
//   o_sc, o_cs_n              serial clock and chip select to the sensor
//   i_si                      SIO pad input (asynchronous, synchronized here)
//   o_so, o_so_oe             host serial data and its output enable
module lm71_spi_master #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_irq,
  output logic        o_sc,
  output logic        o_cs_n,
  input  logic        i_si,
  output logic        o_so,
  output logic        o_so_oe
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned DW = 32;
  localparam int unsigned WW = 16;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_READ,
    S_WRITE,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_bits;
  logic [WW-1:0]   r_rx;
  logic [WW-1:0]   r_tx;
  logic [WW-1:0]   r_txs;
  logic            r_ie;
  logic            r_wr_en;
  logic            r_done;
  logic            r_irq;
  logic            r_si_s1;
  logic            r_si_s2;
  logic            r_sc;
  logic            r_cs_n;
  logic            r_so;
  logic            r_so_oe;
  logic            r_ack;
  logic [DW-1:0]   r_dat;

  logic            w_req;
  logic            w_wr;
  logic            w_rd;
  logic            w_ctrl_wr;
  logic            w_busy;
  logic            w_start;
  logic            w_tick;
  logic            w_fin;
  logic            w_rx_rd;
  logic            w_done_nxt;
  logic            w_ie_nxt;
  logic [DW-1:0]   w_rd_dat;
  logic            w_unused;

  // A request is accepted only while ack is low, so back-to-back strobes ack every other cycle
  assign w_req     = i_wb_cyc & i_wb_stb & ~r_ack;
  assign w_wr      = w_req & i_wb_we;
  assign w_rd      = w_req & ~i_wb_we;
  assign w_ctrl_wr = w_wr & (i_wb_adr == 2'd0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_start   = w_ctrl_wr & i_wb_dat[0] & ~w_busy;
  assign w_tick    = w_busy & (r_cnt == '0);
  assign w_fin     = (r_state == S_HOLD) & w_tick;
  assign w_rx_rd   = w_rd & (i_wb_adr == 2'd1);
  assign w_unused  = ^i_wb_dat[15:3];

  // Next DONE/IE values and the read mux; completion wins over a same-cycle clear
  always_comb begin
    w_ie_nxt   = r_ie;
    w_done_nxt = r_done;
    w_rd_dat   = '0;
    if (w_ctrl_wr) w_ie_nxt = i_wb_dat[2];
    if (w_start || w_rx_rd) w_done_nxt = 1'b0;
    if (w_fin) w_done_nxt = 1'b1;
    case (i_wb_adr)
      2'd0:    w_rd_dat = {r_tx, 12'h000, r_wr_en, r_ie, r_done, w_busy};
      2'd1:    w_rd_dat = {16'h0000, r_rx};
      default: w_rd_dat = '0;
    endcase
  end

  // Wishbone handshake and control/status registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_tx    <= '0;
      r_wr_en <= 1'b0;
      r_ie    <= 1'b0;
      r_done  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_ack  <= w_req;
      r_ie   <= w_ie_nxt;
      r_done <= w_done_nxt;
      r_irq  <= w_done_nxt & w_ie_nxt;
      if (w_rd) r_dat <= w_rd_dat;
      else if (w_wr) r_dat <= '0;
      if (w_ctrl_wr) begin
        r_tx <= i_wb_dat[31:16];
        // WR_EN steers the running transaction, so it is frozen while busy
        if (!w_busy) r_wr_en <= i_wb_dat[1];
      end
    end
  end

  // Two-flop synchronizer for the asynchronous SIO input
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_si_s1 <= 1'b0;
      r_si_s2 <= 1'b0;
    end else begin
      r_si_s1 <= i_si;
      r_si_s2 <= r_si_s1;
    end
  end

  // Half-period tick counter; parked at reload while idle so the first tick lands CLK_DIV after START
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= RELOAD;
    end else if (!w_busy || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Transaction sequencer driving the serial pins
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_bits  <= '0;
      r_rx    <= '0;
      r_txs   <= '0;
      r_sc    <= 1'b0;
      r_cs_n  <= 1'b1;
      r_so    <= 1'b0;
      r_so_oe <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cs_n  <= 1'b0;
            r_bits  <= '0;
            // Snapshot TX so host updates during the transfer do not corrupt the write
            r_txs   <= i_wb_dat[31:16];
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_tick) r_state <= S_READ;
        end
        S_READ: begin
          if (w_tick) begin
            if (!r_sc) begin
              r_sc <= 1'b1;
              r_rx <= {r_rx[WW-2:0], r_si_s2};
            end else begin
              r_sc   <= 1'b0;
              r_bits <= r_bits + 4'd1;
              if (r_bits == 4'd15) begin
                if (r_wr_en) begin
                  r_so_oe <= 1'b1;
                  r_so    <= r_txs[WW-1];
                  r_txs   <= {r_txs[WW-2:0], 1'b0};
                  r_state <= S_WRITE;
                end else begin
                  r_state <= S_HOLD;
                end
              end
            end
          end
        end
        S_WRITE: begin
          if (w_tick) begin
            if (!r_sc) begin
              r_sc <= 1'b1;
            end else begin
              r_sc   <= 1'b0;
              r_bits <= r_bits + 4'd1;
              if (r_bits == 4'd15) begin
                r_so_oe <= 1'b0;
                r_so    <= 1'b0;
                r_state <= S_HOLD;
              end else begin
                r_so  <= r_txs[WW-1];
                r_txs <= {r_txs[WW-2:0], 1'b0};
              end
            end
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            r_cs_n  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wb_dat = r_dat;
  assign o_wb_ack = r_ack;
  assign o_irq    = r_irq;
  assign o_sc     = r_sc;
  assign o_cs_n   = r_cs_n;
  assign o_so     = r_so;
  assign o_so_oe  = r_so_oe;

endmodule

// File: tb/tb_lm71_spi_master.sv
// tb_lm71_spi_master: randomized bench for lm71_spi_master with a behavioural LM71
// model. The model shifts a word out MSB-first (first bit at CS fall, next bit on
// each SC fall) and captures host bits on SC rises while the host drives.
module tb_lm71_spi_master;

  localparam int unsigned CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  adr;
  logic [31:0] dat_w;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_r;
  logic        ack;
  logic        irq;
  logic        sc;
  logic        cs_n;
  logic        si;
  logic        so;
  logic        so_oe;

  int n_checks = 0;
  int n_pass   = 0;

  // Sensor model state
  logic [15:0] word = 16'h0000;
  logic [15:0] cap  = 16'h0000;
  int rises    = 0;
  int oe_rises = 0;
  int oe_start = 0;
  int falls    = 0;
  int falls_at = 0;
  int low_cyc  = 0;
  int idx;

  always #5 clk = ~clk;

  lm71_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .i_wb_adr(adr),
    .i_wb_dat(dat_w),
    .i_wb_we (we),
    .i_wb_cyc(cyc),
    .i_wb_stb(stb),
    .o_wb_dat(dat_r),
    .o_wb_ack(ack),
    .o_irq   (irq),
    .o_sc    (sc),
    .o_cs_n  (cs_n),
    .i_si    (si),
    .o_so    (so),
    .o_so_oe (so_oe)
  );

  always @(posedge sc) begin
    rises <= rises + 1;
    if (so_oe) begin
      oe_rises <= oe_rises + 1;
      cap      <= {cap[14:0], so};
    end
  end
  always @(posedge so_oe) oe_start <= rises;
  always @(negedge sc)    falls <= falls + 1;
  always @(negedge cs_n)  falls_at <= falls;
  always @(negedge clk)   if (cs_n === 1'b0) low_cyc <= low_cyc + 1;

  // Sensor output: bit (15 - number of SC falls since CS went low)
  always_comb begin
    idx = falls - falls_at;
    si  = 1'b0;
    if (cs_n === 1'b0 && idx >= 0 && idx < 16) si = word[4'(15 - idx)];
  end

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    adr = a; dat_w = d; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL wb_write_ack: no ack for adr %0d", a);
    end
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    logic got;
    got = 1'b0;
    d = 32'hxxxx_xxxx;
    @(posedge clk); #1;
    adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; d = dat_r; break; end
    end
    cyc = 1'b0; stb = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL wb_read_ack: no ack for adr %0d", a);
    end
  endtask

  task automatic wait_idle(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (cs_n === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_idle: cs_n still low after %0d cycles", budget);
    end
  endtask

  task automatic wait_rises(input int target, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rises >= target) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_rises: got %0d rises, required %0d", rises, target);
    end
  endtask

  // One full transaction checked against the sensor-level expectations
  task automatic run_xfer(input string tag, input logic [15:0] w, input logic [15:0] tx,
                          input logic wr, input logic ie);
    int r0, o0, l0, exp_rises, exp_low;
    logic [31:0] rd, exp_ctrl;
    word = w;
    r0 = rises; o0 = oe_rises; l0 = low_cyc;
    exp_rises = wr ? 32 : 16;
    exp_low   = (wr ? 66 : 34) * CLK_DIV;
    wb_write(2'd0, {tx, 13'h0, ie, wr, 1'b1});
    wait_idle(100 * CLK_DIV);
    n_checks++;
    if (rises - r0 !== exp_rises) $display("FAIL %s sc_rises: got %0d required %0d", tag, rises - r0, exp_rises);
    else n_pass++;
    n_checks++;
    if (low_cyc - l0 !== exp_low) $display("FAIL %s cs_low: got %0d required %0d", tag, low_cyc - l0, exp_low);
    else n_pass++;
    n_checks++;
    if (oe_rises - o0 !== (wr ? 16 : 0)) $display("FAIL %s oe_rises: got %0d required %0d", tag, oe_rises - o0, wr ? 16 : 0);
    else n_pass++;
    if (wr) begin
      n_checks++;
      if (oe_start - r0 !== 16) $display("FAIL %s oe_window: oe began after %0d rises, required 16", tag, oe_start - r0);
      else n_pass++;
      n_checks++;
      if (cap !== tx) $display("FAIL %s sensor_capture: got %h required %h", tag, cap, tx);
      else n_pass++;
    end
    n_checks++;
    if (irq !== ie) $display("FAIL %s irq: got %b required %b", tag, irq, ie);
    else n_pass++;
    exp_ctrl = {tx, 12'h000, wr, ie, 1'b1, 1'b0};
    wb_read(2'd0, rd);
    n_checks++;
    if (rd !== exp_ctrl) $display("FAIL %s ctrl_status: got %h required %h", tag, rd, exp_ctrl);
    else n_pass++;
    wb_read(2'd1, rd);
    n_checks++;
    if (rd !== {16'h0, w}) $display("FAIL %s rxdata: got %h required %h", tag, rd, {16'h0, w});
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({cs_n, sc, so_oe, ack, irq} !== 5'b10000) $display("FAIL reset_pins: got cs_n,sc,oe,ack,irq=%b required 10000", {cs_n, sc, so_oe, ack, irq});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    wb_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reset_ctrl: got %h required 00000000", rd);
    else n_pass++;
    wb_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reset_rxdata: got %h required 00000000", rd);
    else n_pass++;
  endtask

  task automatic test_read_only();
    run_xfer("read_only", 16'h0C80, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic test_done_clear();
    logic [31:0] rd;
    run_xfer("done_setup", 16'h0C80, 16'h0000, 1'b0, 1'b1);
    // run_xfer ended by reading RXDATA, which clears DONE
    wb_read(2'd0, rd);
    n_checks++;
    if (rd[1] !== 1'b0) $display("FAIL done_clear: DONE got %b required 0", rd[1]);
    else n_pass++;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL done_clear_irq: got %b required 0", irq);
    else n_pass++;
    wb_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reserved_adr2: got %h required 00000000", rd);
    else n_pass++;
    wb_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reserved_adr3: got %h required 00000000", rd);
    else n_pass++;
  endtask

  task automatic test_read_write();
    run_xfer("read_write", 16'($urandom), 16'hFFFF, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      run_xfer($sformatf("random%0d", k), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_start_busy();
    logic [31:0] rd;
    int r0;
    word = 16'($urandom);
    r0 = rises;
    wb_write(2'd0, 32'h0000_0001);
    wait_rises(r0 + 5, 40 * CLK_DIV);
    wb_write(2'd0, 32'hABCD_0007);
    wb_read(2'd0, rd);
    n_checks++;
    if (rd[0] !== 1'b1) $display("FAIL busy_start_busy: BUSY got %b required 1", rd[0]);
    else n_pass++;
    n_checks++;
    if ({rd[31:16], rd[2]} !== {16'hABCD, 1'b1}) $display("FAIL busy_tx_ie: got tx=%h ie=%b required tx=abcd ie=1", rd[31:16], rd[2]);
    else n_pass++;
    wait_idle(100 * CLK_DIV);
    repeat (40 * CLK_DIV) @(posedge clk);
    #1;
    n_checks++;
    if (rises - r0 !== 16) $display("FAIL busy_one_xfer: got %0d rises required 16", rises - r0);
    else n_pass++;
    n_checks++;
    if (cs_n !== 1'b1) $display("FAIL busy_cs_idle: got %b required 1", cs_n);
    else n_pass++;
    wb_read(2'd1, rd);
    n_checks++;
    if (rd !== {16'h0, word}) $display("FAIL busy_rxdata: got %h required %h", rd, {16'h0, word});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int r0;
    word = 16'($urandom);
    r0 = rises;
    wb_write(2'd0, 32'h1234_0003);
    wait_rises(r0 + 7, 40 * CLK_DIV);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cs_n, sc, so_oe} !== 3'b100) $display("FAIL reset_mid_pins: got cs_n,sc,oe=%b required 100", {cs_n, sc, so_oe});
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    wb_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reset_mid_ctrl: got %h required 00000000", rd);
    else n_pass++;
    run_xfer("after_reset", 16'($urandom), 16'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    adr = 2'd0; dat_w = 32'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    test_reset();
    test_read_only();
    test_done_clear();
    test_read_write();
    test_random();
    test_start_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
